uart_rx_frame: RTL and testbench

- UART receiver for the 11-bit frame format used by the transmit path: start (0), data[6:0] LSB first, then three trailing bits e0, e1, e2.
- The meaning of e0..e2 is set by bit8, parity_en and odd_n_even.
- Oversamples the serial line, recovers data, checks parity and stop bits, and holds the result until the host acknowledges it.
- Sits between the rx pad synchronizer and the host register interface.

---
 rtl/uart_pkg.sv | 55 +++++
 rtl/uart_baud_cnt.sv | 38 +++
 rtl/uart_rx_frame.sv | 146 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame receive/transmit paths: FSM states, frame geometry
// and the trailing-bit decode that turns raw samples into a byte plus error flags.
package uart_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StData, StDone} uart_state_e;

  localparam int unsigned DATA_BITS_MIN = 7;
  localparam int unsigned TRAIL_BITS    = 3;
  localparam int unsigned LAST_IDX      = 9;

  // Role of e0..e2, selected by {bit8, parity_en}
  localparam logic [1:0] TrailStop3 = 2'b00;
  localparam logic [1:0] TrailPar   = 2'b01;
  localparam logic [1:0] TrailD7    = 2'b10;
  localparam logic [1:0] TrailD7Par = 2'b11;

  typedef struct packed {
    logic bit8;
    logic parity_en;
    logic odd_n_even;
  } uart_cfg_t;

  typedef struct packed {
    logic [7:0] data;
    logic       parity_err;
    logic       frame_err;
  } uart_result_t;

  function automatic uart_result_t uart_decode(uart_cfg_t cfg, logic [DATA_BITS_MIN-1:0] d,
                                               logic [TRAIL_BITS-1:0] e);
    uart_result_t res;
    logic         pbit;
    logic         stops_ok;
    res.data = cfg.bit8 ? {e[0], d} : {1'b0, d};
    pbit     = 1'b0;
    stops_ok = 1'b1;
    case ({cfg.bit8, cfg.parity_en})
      TrailStop3: stops_ok = &e;
      TrailPar: begin
        pbit     = e[0];
        stops_ok = &e[2:1];
      end
      TrailD7:  stops_ok = &e[2:1];
      default: begin
        pbit     = e[1];
        stops_ok = e[2];
      end
    endcase
    // Odd parity flips the expected bit relative to the plain XOR
    res.parity_err = cfg.parity_en & (pbit ^ (^res.data) ^ cfg.odd_n_even);
    res.frame_err  = ~stops_ok;
    return res;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter: loads a full-bit or half-bit period and flags the cycle it
// reaches zero while enabled. Shared by the receive and transmit paths.
module uart_baud_cnt #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic load_i,
  input  logic half_i,
  output logic tick_o
);

  localparam int unsigned CntW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = half_i ? CntW'(HALF_DIV - 1) : CntW'(BAUD_DIV - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver for the 11-bit frame (start, 7 data bits, e0..e2): synchronizes rx, samples
// each bit centre from the start edge, decodes parity/stop bits and holds the byte for the host.
module uart_rx_frame #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  import uart_pkg::*;

  logic                     rx_meta_q, rx_s_q, rx_s_prev_q;
  uart_state_e              state_q;
  logic [3:0]               idx_q;
  logic [DATA_BITS_MIN-1:0] d_q;
  logic [TRAIL_BITS-1:0]    e_q;
  uart_cfg_t                cfg_q;
  logic [7:0]               rx_data_q;
  logic                     rx_rdy_q, parity_err_q, frame_err_q, overrun_q;

  logic         start_evt;
  logic         cnt_en, cnt_load, cnt_half, tick;
  uart_result_t dec;

  assign start_evt = (state_q == StIdle) && rx_s_prev_q && !rx_s_q;
  assign cnt_en    = (state_q == StStart) || (state_q == StData);
  assign dec       = uart_decode(cfg_q, d_q, e_q);

  always_comb begin
    cnt_load = 1'b0;
    cnt_half = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_load = start_evt;
        cnt_half = 1'b1;
      end
      StStart: cnt_load = tick && !rx_s_q;
      StData:  cnt_load = tick;
      default: cnt_load = 1'b0;
    endcase
  end

  uart_baud_cnt #(
    .BAUD_DIV(BAUD_DIV),
    .HALF_DIV(HALF_DIV)
  ) u_baud_cnt (
    .clk_i (clk),
    .rst_i (rstb),
    .en_i  (cnt_en),
    .load_i(cnt_load),
    .half_i(cnt_half),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (rstb) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_s_prev_q  <= 1'b1;
      state_q      <= StIdle;
      idx_q        <= '0;
      d_q          <= '0;
      e_q          <= '0;
      cfg_q        <= '0;
      rx_data_q    <= '0;
      rx_rdy_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_s_prev_q <= rx_s_q;

      case (state_q)
        StIdle: begin
          if (start_evt) begin
            cfg_q   <= '{bit8: bit8, parity_en: parity_en, odd_n_even: odd_n_even};
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            if (rx_s_q) begin
              state_q <= StIdle;
            end else begin
              idx_q   <= '0;
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (tick) begin
            // Both registers shift in from the top, so the first sample lands in bit 0
            if (idx_q < 4'(DATA_BITS_MIN)) begin
              d_q <= {rx_s_q, d_q[DATA_BITS_MIN-1:1]};
            end else begin
              e_q <= {rx_s_q, e_q[TRAIL_BITS-1:1]};
            end
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'(LAST_IDX)) begin
              state_q <= StDone;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // A completing frame takes priority over a simultaneous host read
      if (state_q == StDone) begin
        rx_data_q    <= dec.data;
        parity_err_q <= dec.parity_err;
        frame_err_q  <= dec.frame_err;
        rx_rdy_q     <= 1'b1;
        overrun_q    <= rd ? 1'b0 : (overrun_q | rx_rdy_q);
      end else if (rd && rx_rdy_q) begin
        rx_rdy_q     <= 1'b0;
        parity_err_q <= 1'b0;
        frame_err_q  <= 1'b0;
        overrun_q    <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_rdy     = rx_rdy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed vector table, corner-case sequences and
// randomized frames scored against a frame-level reference model.
module tb_uart_rx_frame;

  localparam int unsigned Baud = 16;

  logic       clk = 1'b0;
  logic       rstb, rx, bit8, parity_en, odd_n_even, rd;
  logic [7:0] rx_data;
  logic       rx_rdy, parity_err, frame_err, overrun, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_frame #(
    .BAUD_DIV(Baud),
    .HALF_DIV(Baud / 2)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .rx        (rx),
    .bit8      (bit8),
    .parity_en (parity_en),
    .odd_n_even(odd_n_even),
    .rd        (rd),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct packed {
    logic [2:0] mode;
    logic [6:0] d;
    logic [2:0] e;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Frame-level model: byte, parity and stop positions worked out from the frame layout
  task automatic ref_model(input logic [2:0] mode, input logic [6:0] d, input logic [2:0] e,
                           output logic [7:0] data, output logic pe, output logic fe);
    int ones;
    int first_stop;
    int pidx;
    logic want;
    data = {(mode[2] ? e[0] : 1'b0), d};
    ones = $countones(data);
    want = mode[0] ? ((ones % 2) == 0) : ((ones % 2) == 1);
    pidx = mode[2] ? 1 : 0;
    pe = mode[1] && (e[pidx] != want);
    first_stop = (mode[2] ? 1 : 0) + (mode[1] ? 1 : 0);
    fe = 1'b0;
    for (int i = first_stop; i < 3; i++) begin
      if (e[i] == 1'b0) fe = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [2:0] mode, input logic [6:0] d, input logic [2:0] e);
    logic [2:0] junk;
    {bit8, parity_en, odd_n_even} = mode;
    rx = 1'b0;
    repeat (Baud) tick();
    // Config is latched at the start edge; scrambling it now must not matter
    junk = 3'($urandom);
    {bit8, parity_en, odd_n_even} = junk;
    for (int i = 0; i < 7; i++) begin
      rx = d[i];
      repeat (Baud) tick();
    end
    for (int i = 0; i < 3; i++) begin
      rx = e[i];
      repeat (Baud) tick();
    end
    rx = 1'b1;
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!rx_rdy && n < 2 * Baud) begin
      tick();
      n++;
    end
    check({name, " rx_rdy"}, {7'd0, rx_rdy}, 8'd1);
  endtask

  task automatic do_rd(input string name);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check({name, " rdy after rd"}, {7'd0, rx_rdy}, 8'd0);
    check({name, " flags after rd"}, {5'd0, parity_err, frame_err, overrun}, 8'd0);
  endtask

  initial begin
    logic [2:0] mode;
    logic [6:0] d;
    logic [2:0] e;
    logic [7:0] m_data;
    logic       m_pe, m_fe;

    tbl[0] = '{mode: 3'b000, d: 7'h55, e: 3'b111, exp_data: 8'h55, exp_pe: 1'b0, exp_fe: 1'b0};
    tbl[1] = '{mode: 3'b110, d: 7'h25, e: 3'b101, exp_data: 8'hA5, exp_pe: 1'b0, exp_fe: 1'b0};
    tbl[2] = '{mode: 3'b110, d: 7'h25, e: 3'b111, exp_data: 8'hA5, exp_pe: 1'b1, exp_fe: 1'b0};
    tbl[3] = '{mode: 3'b011, d: 7'h03, e: 3'b111, exp_data: 8'h03, exp_pe: 1'b0, exp_fe: 1'b0};
    tbl[4] = '{mode: 3'b000, d: 7'h03, e: 3'b011, exp_data: 8'h03, exp_pe: 1'b0, exp_fe: 1'b1};

    rstb = 1'b1;
    rx = 1'b1;
    rd = 1'b0;
    {bit8, parity_en, odd_n_even} = 3'b000;
    repeat (3) tick();
    check("reset data", rx_data, 8'h00);
    check("reset flags", {3'd0, rx_rdy, parity_err, frame_err, overrun, busy}, 8'h00);
    rstb = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].mode, tbl[i].d, tbl[i].e);
      wait_rdy($sformatf("vec%0d", i));
      check($sformatf("vec%0d data", i), rx_data, tbl[i].exp_data);
      check($sformatf("vec%0d parity_err", i), {7'd0, parity_err}, {7'd0, tbl[i].exp_pe});
      check($sformatf("vec%0d frame_err", i), {7'd0, frame_err}, {7'd0, tbl[i].exp_fe});
      check($sformatf("vec%0d overrun", i), {7'd0, overrun}, 8'd0);
      do_rd($sformatf("vec%0d", i));
      repeat (Baud) tick();
    end

    // False start: a 6-cycle glitch must not produce a byte
    rx = 1'b0;
    repeat (6) tick();
    check("glitch busy", {7'd0, busy}, 8'd1);
    rx = 1'b1;
    repeat (12) tick();
    check("glitch idle", {6'd0, busy, rx_rdy}, 8'd0);
    repeat (Baud) tick();

    // Back-to-back frames without a read
    send_frame(3'b000, 7'h12, 3'b111);
    send_frame(3'b000, 7'h34, 3'b111);
    wait_rdy("overrun");
    check("overrun data", rx_data, 8'h34);
    check("overrun flag", {7'd0, overrun}, 8'd1);
    do_rd("overrun");
    repeat (Baud) tick();

    // Reset in the middle of a frame with a byte already held
    send_frame(3'b000, 7'h55, 3'b111);
    wait_rdy("pre-reset");
    repeat (Baud) tick();
    {bit8, parity_en, odd_n_even} = 3'b000;
    rx = 1'b0;
    repeat (Baud) tick();
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (Baud) tick();
    end
    repeat (Baud / 2) tick();
    check("midframe busy", {7'd0, busy}, 8'd1);
    rstb = 1'b1;
    tick();
    rstb = 1'b0;
    check("midreset data", rx_data, 8'h00);
    check("midreset flags", {3'd0, rx_rdy, parity_err, frame_err, overrun, busy}, 8'h00);
    repeat (2 * Baud) tick();
    check("post-reset quiet", {7'd0, rx_rdy}, 8'd0);
    send_frame(3'b000, 7'h7F, 3'b111);
    wait_rdy("post-reset");
    check("post-reset data", rx_data, 8'h7F);
    check("post-reset flags", {5'd0, parity_err, frame_err, overrun}, 8'h00);
    do_rd("post-reset");
    repeat (4) tick();

    // Randomized frames against the reference model
    for (int n = 0; n < 40; n++) begin
      mode = 3'($urandom_range(0, 7));
      d = 7'($urandom);
      e = 3'($urandom);
      ref_model(mode, d, e, m_data, m_pe, m_fe);
      send_frame(mode, d, e);
      wait_rdy($sformatf("rand%0d", n));
      check($sformatf("rand%0d data", n), rx_data, m_data);
      check($sformatf("rand%0d pe/fe/ovr", n), {5'd0, parity_err, frame_err, overrun},
            {5'd0, m_pe, m_fe, 1'b0});
      do_rd($sformatf("rand%0d", n));
      repeat ($urandom_range(2, Baud)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
